board_scan_scheduler: RTL and testbench
=======================================

# board_scan_scheduler

Owns the single-port board-state RAM of the Gomoku UI (15×15 cells, 2 bits each) and shares it between the VGA scan-out path and the game-logic host port. During each horizontal blanking interval it prefetches the 15 cells of the next scanline's board row into an internal line buffer, and it serves host reads and writes in the remaining cycles. It also maps the VGA timing generator's `h_cnt`/`v_cnt` to a registered per-pixel cell state for the renderer.

## Interface
- `BOARD_N`, 15: cells per side; the RAM holds BOARD_N² entries.
- `CELL_PX`, 32: cell size in pixels; must be a power of two.
- `X_OFF`, 80: first board pixel column.
- `Y_OFF`, 0: first board pixel line.
- `VD`, 480: active lines per frame.
- `pclk`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high.
- `valid`, `vsync`  in  1 each  from the VGA timing generator; `vsync` is active-low.
- `h_cnt`, `v_cnt`  in  10 each  active-region pixel and line counters, forced to 0 outside the active region.
- `host_req`  in  1  host access request, level, held until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  8  cell index, computed as row*BOARD_N + col.
- `host_wdata`  in  2  cell value.
- `host_ack`  out  1  one-cycle completion pulse.
- `host_rdata`  out  2  read data; valid only while `host_ack` = 1.
- `mem_en`, `mem_we`  out  1 each  RAM strobes.
- `mem_addr`  out  8  RAM address.
- `mem_wdata`  out  2  RAM write data.
- `mem_rdata`  in  2  RAM read data, valid the cycle after `mem_en` with `mem_we` = 0.
- `pix_on_board`  out  1  the current pixel lies inside the board.
- `pix_cell`  out  2  cell state at the current pixel.

## Operation
**Fetch triggers**
- A trigger is detected combinationally in cycle T:
  - falling edge of `valid` (`valid_q & ~valid`), targeting `next_line` = (`v_cnt` == VD-1) ? 0 : `v_cnt`+1;
  - falling edge of `vsync`, targeting `next_line` = 0.
- Target row = (`next_line` − Y_OFF) >> log2(CELL_PX).
- If `next_line` is outside [Y_OFF, Y_OFF+BOARD_N*CELL_PX), no fetch is started.
- A trigger arriving while the FSM is in FETCH, HOST or HOST_ACK sets `pend` and latches the target row. A newer trigger overwrites the latched row.

**FSM states: IDLE, FETCH, DRAIN, HOST, HOST_ACK**
- IDLE:
  - on a trigger or `pend`, go to FETCH with `c` = 0; this takes priority over the host;
  - else on `host_req`, go to HOST;
  - `pend` is cleared on entry to FETCH.
- FETCH: drive `mem_en` = 1, `mem_we` = 0, `mem_addr` = row*BOARD_N + c.
  - When c > 0, write `mem_rdata` into `linebuf[c-1]`.
  - c = 0..14; after c = 14, go to DRAIN.
- DRAIN: write `mem_rdata` into `linebuf[14]`. Next state:
  - FETCH if `pend`;
  - else HOST if `host_req`;
  - else IDLE.
- HOST: if `host_addr` < BOARD_N², drive `mem_en` = 1, `mem_we` = `host_we`, `mem_addr` = `host_addr`, `mem_wdata` = `host_wdata`. Otherwise assert no strobe. Go to HOST_ACK.
- HOST_ACK: `host_ack` = 1.
  - `host_rdata` = `mem_rdata` for an in-range read, else 0.
  - Go to FETCH if `pend`, else IDLE.
- The host drops `host_req` on the edge at which it samples `host_ack` = 1. If `host_req` is still high in the following IDLE cycle, it is a new request.
- Out-of-range host accesses are acknowledged normally. Writes are discarded; reads return 0.
- Cell value 2'b11 is stored and returned unchanged.

**Pixel lookup**
- `pix_on_board` = `valid` && `h_cnt` in [X_OFF, X_OFF+BOARD_N*CELL_PX) && `v_cnt` in the board's row range.
- `pix_cell` = `linebuf[(h_cnt − X_OFF) >> log2 CELL_PX]` when on board, else 0.
- Both outputs are registered.

## Timing
- All outputs reset to 0. Reset also forces:
  - state = IDLE, `pend` = 0, `valid_q` = 0, `vsync_q` = 1;
  - `linebuf` cleared to 0.
- Reset takes effect on the next edge, including mid-fetch or mid-host access. An aborted fetch leaves `linebuf` cleared.
- Fetch latency, with trigger in cycle T:
  - FETCH occupies T+1..T+15, with `mem_addr` = row*15 .. row*15+14;
  - DRAIN is at T+16;
  - `linebuf` is complete at the T+16 edge. This is well inside the 160-pixel horizontal blanking interval.
- Host latency:
  - `host_req` seen in IDLE at cycle k: HOST at k+1 (RAM strobe), `host_ack` at k+2;
  - `host_req` waiting behind a fetch: HOST at T+17, `host_ack` at T+18.
- Trigger and `host_req` in the same IDLE cycle: the fetch goes first.
- A host write lands in RAM at the HOST edge. It becomes visible on screen only after the next fetch of that row.
- `pix_on_board` and `pix_cell` lag `h_cnt`/`v_cnt` by exactly 1 cycle.

## Test plan
1. **Reset.** Hold `reset` for 3 cycles mid-FETCH → all outputs 0; state IDLE; `linebuf` all 0.
2. **Host write.** In IDLE, write `host_addr` = 17, `host_wdata` = 2'b01 → at k+1, `mem_we` = 1 and `mem_addr` = 17; `host_ack` = 1 at k+2 only.
3. **Host read.** Read `host_addr` = 17 → `host_rdata` = 2'b01 with `host_ack`.
4. **Row fetch.** Preload RAM cells 15..29. Drop `valid` with `v_cnt` = 31 → `mem_addr` = 15..29 in T+1..T+15. Then on line 32 with `h_cnt` = 176, one cycle later `pix_on_board` = 1 and `pix_cell` = RAM[18].
5. **Collision.** Assert `host_req` in the same cycle as a `valid` fall → fetch runs first; HOST at T+17; `host_ack` at T+18.
6. **Out-of-range and off-board.**
   - `host_addr` = 230 read → `host_ack` = 1, `host_rdata` = 0, `mem_en` never asserted.
   - `h_cnt` = 50 → `pix_on_board` = 0, `pix_cell` = 0.
   - `valid` fall at `v_cnt` = 479 → row 0 fetched, `mem_addr` = 0..14.

Source files
------------

// File: rtl/board_scan_scheduler.sv
// Board-state RAM arbiter for the Gomoku UI. Prefetches one board row into a
// line buffer during each horizontal blanking interval, serves host accesses
// in the remaining cycles and produces a registered per-pixel cell state.
module board_scan_scheduler #(
  parameter int BOARD_N = 15,
  parameter int CELL_PX = 32,
  parameter int X_OFF   = 80,
  parameter int Y_OFF   = 0,
  parameter int VD      = 480
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       valid,
  input  logic       vsync,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [1:0] host_wdata,
  output logic       host_ack,
  output logic [1:0] host_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  output logic       pix_on_board,
  output logic [1:0] pix_cell
);
  localparam int                LOG2     = $clog2(CELL_PX);
  localparam int                IDX_W    = $clog2(BOARD_N);
  localparam logic [10:0]       BOARD_PX = 11'(BOARD_N * CELL_PX);
  localparam logic [10:0]       X_O      = 11'(X_OFF);
  localparam logic [10:0]       Y_O      = 11'(Y_OFF);
  localparam logic [9:0]        LAST_LN  = 10'(VD - 1);
  localparam logic [7:0]        N8       = 8'(BOARD_N);
  localparam logic [8:0]        CELLS    = 9'(BOARD_N * BOARD_N);
  localparam logic [IDX_W-1:0]  LAST_C   = IDX_W'(BOARD_N - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOST, HOST_ACK} state_t;

  state_t           state, state_nx;
  logic             valid_q, vsync_q, pend;
  logic [7:0]       pend_row, row_q;
  logic [IDX_W-1:0] c;
  logic [1:0]       linebuf [BOARD_N];

  // Trigger detection: blanking start (valid fall) or frame start (vsync fall)
  logic        vs_fall, vl_fall, trig, fetch_go, host_in;
  logic [9:0]  next_line;
  logic [10:0] ndiff, hdiff, vdiff;
  logic [7:0]  trig_row;

  assign vs_fall   = vsync_q & ~vsync;
  assign vl_fall   = valid_q & ~valid;
  assign trig      = vs_fall | vl_fall;
  assign next_line = (vs_fall || v_cnt == LAST_LN) ? 10'd0 : v_cnt + 10'd1;
  // Bit 10 of the difference is the borrow: line lies above the board
  assign ndiff     = {1'b0, next_line} - Y_O;
  assign fetch_go  = trig & ~ndiff[10] & (ndiff < BOARD_PX);
  assign trig_row  = 8'(ndiff >> LOG2);
  assign host_in   = {1'b0, host_addr} < CELLS;

  // Control state, fetch counter and pending-trigger bookkeeping
  always_ff @(posedge pclk) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= 1'b0;
      pend_row <= '0;
      row_q    <= '0;
      c        <= '0;
      valid_q  <= 1'b0;
      vsync_q  <= 1'b1;
    end else begin
      state   <= state_nx;
      valid_q <= valid;
      vsync_q <= vsync;
      if (state_nx == FETCH && state != FETCH) begin
        // A trigger in this very cycle is newer than anything pending
        c     <= '0;
        row_q <= fetch_go ? trig_row : pend_row;
        pend  <= 1'b0;
      end else begin
        if (state == FETCH) c <= c + 1'b1;
        if (fetch_go) begin
          pend     <= 1'b1;
          pend_row <= trig_row;
        end
      end
    end
  end

  // Next-state and RAM/host strobes; fetch outranks the host everywhere
  always_comb begin
    state_nx   = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_ack   = 1'b0;
    host_rdata = '0;
    case (state)
      IDLE: begin
        if (pend || fetch_go) state_nx = FETCH;
        else if (host_req)    state_nx = HOST;
      end
      FETCH: begin
        mem_en   = 1'b1;
        mem_addr = row_q * N8 + 8'(c);
        if (c == LAST_C) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pend || fetch_go) state_nx = FETCH;
        else if (host_req)    state_nx = HOST;
        else                  state_nx = IDLE;
      end
      HOST: begin
        if (host_in) begin
          mem_en    = 1'b1;
          mem_we    = host_we;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
        end
        state_nx = HOST_ACK;
      end
      HOST_ACK: begin
        host_ack = 1'b1;
        if (host_in && !host_we) host_rdata = mem_rdata;
        state_nx = (pend || fetch_go) ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line buffer fill: read data trails the address by one cycle
  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < BOARD_N; i++) linebuf[i] <= '0;
    end else if (state == FETCH && c != '0) begin
      linebuf[c - 1'b1] <= mem_rdata;
    end else if (state == DRAIN) begin
      linebuf[LAST_C] <= mem_rdata;
    end
  end

  assign hdiff = {1'b0, h_cnt} - X_O;
  assign vdiff = {1'b0, v_cnt} - Y_O;

  // Registered pixel lookup, one cycle behind h_cnt/v_cnt
  always_ff @(posedge pclk) begin
    if (reset) begin
      pix_on_board <= 1'b0;
      pix_cell     <= '0;
    end else begin
      pix_on_board <= valid & ~hdiff[10] & (hdiff < BOARD_PX) & ~vdiff[10] & (vdiff < BOARD_PX);
      if (valid && !hdiff[10] && hdiff < BOARD_PX && !vdiff[10] && vdiff < BOARD_PX)
        pix_cell <= linebuf[IDX_W'(hdiff >> LOG2)];
      else
        pix_cell <= '0;
    end
  end
endmodule

// File: tb/tb_board_scan_scheduler.sv
// Self-checking bench for board_scan_scheduler: host access table, pixel
// lookup table, hand-written fetch/collision/reset sequences and a randomized
// phase checked against an array-based model of RAM and line buffer.
module tb_board_scan_scheduler;
  logic       pclk = 1'b0;
  logic       reset, valid, vsync;
  logic [9:0] h_cnt, v_cnt;
  logic       host_req, host_we;
  logic [7:0] host_addr;
  logic [1:0] host_wdata;
  logic       host_ack;
  logic [1:0] host_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata = 2'b00;
  logic       pix_on_board;
  logic [1:0] pix_cell;

  int tests = 0;
  int fails = 0;

  // Environment RAM plus a bench-only preload port
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'd0;
  logic [1:0] pre_data = 2'b00;
  logic [1:0] ram [256];

  // Expectation model: intended board contents and the row last fetched
  int exp_ram [225];
  int model_lb [15];

  board_scan_scheduler dut (
    .pclk(pclk), .reset(reset), .valid(valid), .vsync(vsync),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_on_board(pix_on_board), .pix_cell(pix_cell)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_en"}, int'(mem_en), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_host_ack"}, int'(host_ack), 0);
    chk({tag, "_pix_on"}, int'(pix_on_board), 0);
    chk({tag, "_pix_cell"}, int'(pix_cell), 0);
  endtask

  // Issue one host access and wait (bounded) for the acknowledge
  task automatic host_op(input bit we, input int addr, input int wd,
                         output int rd, output int lat, output int strobes,
                         output int s_addr, output int s_we, output int s_wd);
    host_req = 1'b1; host_we = we; host_addr = 8'(addr); host_wdata = 2'(wd);
    lat = 0; strobes = 0; s_addr = -1; s_we = -1; s_wd = -1; rd = -1;
    #1;
    while (!host_ack && lat < 40) begin
      tick();
      lat++;
      if (mem_en) begin
        strobes++; s_addr = int'(mem_addr); s_we = int'(mem_we); s_wd = int'(mem_wdata);
      end
    end
    if (!host_ack) chk("host_ack_timeout", 0, 1);
    rd = int'(host_rdata);
    tick();
    host_req = 1'b0;
  endtask

  // Raise a fetch trigger from IDLE and check the full fetch address sweep
  task automatic do_fetch(input int vline, input bit use_vs);
    int nl, row;
    nl  = use_vs ? 0 : ((vline == 479) ? 0 : vline + 1);
    row = nl / 32;
    if (!use_vs) begin
      valid = 1'b1; v_cnt = 10'(vline); h_cnt = 10'd176;
      tick();
      valid = 1'b0;
    end else begin
      vsync = 1'b0;
    end
    tick();
    if (!use_vs) begin
      chk("valid_low_pix_on", int'(pix_on_board), 0);
      chk("valid_low_pix_cell", int'(pix_cell), 0);
    end
    vsync = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("fetch_mem_en", int'(mem_en), 1);
      chk("fetch_mem_we", int'(mem_we), 0);
      chk("fetch_mem_addr", int'(mem_addr), row * 15 + i);
      tick();
    end
    chk("drain_mem_en", int'(mem_en), 0);
    tick();
    for (int k = 0; k < 15; k++) model_lb[k] = exp_ram[row * 15 + k];
  endtask

  // Present one on-board-or-not pixel and check the registered result
  task automatic pix_chk(input int v, input int h, input string tag);
    int exp_on, exp_cell;
    valid = 1'b1; v_cnt = 10'(v); h_cnt = 10'(h);
    tick();
    exp_on   = (h >= 80 && h < 560 && v < 480) ? 1 : 0;
    exp_cell = exp_on ? model_lb[(h - 80) / 32] : 0;
    chk({tag, "_pix_on"}, int'(pix_on_board), exp_on);
    chk({tag, "_pix_cell"}, int'(pix_cell), exp_cell);
  endtask

  typedef struct {
    bit we; int addr; int wd; int exp_rd; int exp_strobes;
  } host_vec_t;

  typedef struct {
    int v; int h; int exp_on; int exp_cell;
  } pix_vec_t;

  host_vec_t hv [13];
  pix_vec_t  pv [10];

  initial begin
    int rd, lat, st, sa, sw, sd;
    int row, nl;

    hv[0]  = '{1'b1, 17,  1, 0, 1};
    hv[1]  = '{1'b0, 17,  0, 1, 1};
    hv[2]  = '{1'b1, 200, 3, 0, 1};
    hv[3]  = '{1'b0, 200, 0, 3, 1};
    hv[4]  = '{1'b1, 224, 2, 0, 1};
    hv[5]  = '{1'b0, 224, 0, 2, 1};
    hv[6]  = '{1'b1, 225, 3, 0, 0};
    hv[7]  = '{1'b0, 225, 0, 0, 0};
    hv[8]  = '{1'b0, 230, 0, 0, 0};
    hv[9]  = '{1'b1, 0,   3, 0, 1};
    hv[10] = '{1'b0, 0,   0, 3, 1};
    hv[11] = '{1'b0, 255, 0, 0, 0};
    hv[12] = '{1'b0, 14,  0, 2, 1};

    pv[0] = '{32, 176, 1, 2};
    pv[1] = '{40, 80,  1, 3};
    pv[2] = '{40, 79,  0, 0};
    pv[3] = '{33, 559, 1, 1};
    pv[4] = '{33, 560, 0, 0};
    pv[5] = '{32, 50,  0, 0};
    pv[6] = '{63, 111, 1, 3};
    pv[7] = '{63, 112, 1, 0};
    pv[8] = '{50, 300, 1, 1};
    pv[9] = '{50, 639, 0, 0};

    reset = 1'b1; valid = 1'b0; vsync = 1'b1; h_cnt = '0; v_cnt = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int k = 0; k < 15; k++) model_lb[k] = 0;
    repeat (3) tick();
    chk_quiet("reset_init");
    chk("reset_init_rdata", int'(host_rdata), 0);
    reset = 1'b0;
    tick();

    // Preload: in-range cells hold i%4, out-of-range cells hold 3
    for (int i = 0; i < 256; i++) begin
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = (i < 225) ? 2'(i % 4) : 2'b11;
      if (i < 225) exp_ram[i] = i % 4;
      tick();
    end
    pre_we = 1'b0;
    tick();

    // Host access table
    for (int i = 0; i < 13; i++) begin
      host_op(hv[i].we, hv[i].addr, hv[i].wd, rd, lat, st, sa, sw, sd);
      chk($sformatf("host%0d_latency", i), lat, 2);
      chk($sformatf("host%0d_strobes", i), st, hv[i].exp_strobes);
      if (hv[i].exp_strobes == 1) begin
        chk($sformatf("host%0d_addr", i), sa, hv[i].addr);
        chk($sformatf("host%0d_we", i), sw, int'(hv[i].we));
        if (hv[i].we) chk($sformatf("host%0d_wdata", i), sd, hv[i].wd);
      end
      if (!hv[i].we) chk($sformatf("host%0d_rdata", i), rd, hv[i].exp_rd);
      if (hv[i].we && hv[i].addr < 225) exp_ram[hv[i].addr] = hv[i].wd;
      chk($sformatf("host%0d_ack_gone", i), int'(host_ack), 0);
    end

    // Row 1 fetch, then pixel table (all with valid high)
    do_fetch(31, 1'b0);
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1; v_cnt = 10'(pv[i].v); h_cnt = 10'(pv[i].h);
      tick();
      chk($sformatf("pix%0d_on", i), int'(pix_on_board), pv[i].exp_on);
      chk($sformatf("pix%0d_cell", i), int'(pix_cell), pv[i].exp_cell);
    end

    // Last line wraps to row 0; vsync fall also targets row 0
    do_fetch(479, 1'b0);
    pix_chk(5, 80, "row0_col0");
    do_fetch(0, 1'b1);
    pix_chk(5, 100, "vs_row0");

    // Host request in the same cycle as the trigger: fetch first
    valid = 1'b1; v_cnt = 10'd100; tick();
    valid = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd17;
    #1;
    chk("coll_T_ack", int'(host_ack), 0);
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      if (cyc <= 15) begin
        chk("coll_fetch_en", int'(mem_en), 1);
        chk("coll_fetch_addr", int'(mem_addr), 45 + cyc - 1);
        chk("coll_fetch_ack", int'(host_ack), 0);
      end else if (cyc == 16) begin
        chk("coll_drain_en", int'(mem_en), 0);
        chk("coll_drain_ack", int'(host_ack), 0);
      end else if (cyc == 17) begin
        chk("coll_host_en", int'(mem_en), 1);
        chk("coll_host_we", int'(mem_we), 0);
        chk("coll_host_addr", int'(mem_addr), 17);
        chk("coll_host_ack", int'(host_ack), 0);
      end else begin
        chk("coll_ack", int'(host_ack), 1);
        chk("coll_rdata", int'(host_rdata), exp_ram[17]);
      end
    end
    tick();
    host_req = 1'b0;
    for (int k = 0; k < 15; k++) model_lb[k] = exp_ram[45 + k];
    pix_chk(100, 400, "row3");

    // Reset in the middle of a fetch
    valid = 1'b1; v_cnt = 10'd199; h_cnt = 10'd176; tick();
    valid = 1'b0; tick();
    repeat (4) tick();
    valid = 1'b1; v_cnt = 10'd32; h_cnt = 10'd400; tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet($sformatf("rst%0d", i));
    end
    reset = 1'b0;
    tick();
    for (int k = 0; k < 15; k++) model_lb[k] = 0;
    chk("rst_after_on", int'(pix_on_board), 1);
    chk("rst_after_cell", int'(pix_cell), 0);
    chk("rst_after_idle", int'(mem_en), 0);
    host_op(1'b0, 18, 0, rd, lat, st, sa, sw, sd);
    chk("rst_host_latency", lat, 2);
    chk("rst_host_rdata", rd, exp_ram[18]);

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      int op, a, d;
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 255));
      d  = int'($urandom_range(0, 3));
      case (op)
        0: begin
          host_op(1'b1, a, d, rd, lat, st, sa, sw, sd);
          chk("rnd_wr_latency", lat, 2);
          chk("rnd_wr_strobes", st, (a < 225) ? 1 : 0);
          if (a < 225) exp_ram[a] = d;
        end
        1: begin
          host_op(1'b0, a, 0, rd, lat, st, sa, sw, sd);
          chk("rnd_rd_latency", lat, 2);
          chk("rnd_rd_data", rd, (a < 225) ? exp_ram[a] : 0);
        end
        2: begin
          a  = int'($urandom_range(0, 479));
          nl = (a == 479) ? 0 : a + 1;
          row = nl / 32;
          do_fetch(a, 1'b0);
          for (int j = 0; j < 4; j++)
            pix_chk(row * 32 + int'($urandom_range(0, 31)), int'($urandom_range(0, 639)), "rnd_fetch");
        end
        default: begin
          for (int j = 0; j < 3; j++)
            pix_chk(int'($urandom_range(0, 479)), int'($urandom_range(0, 639)), "rnd_pix");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
